// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, select and opcode encodings for the multicycle RV32I sequencer
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/multicycle_fsm_alu_decoder.sv
// rtl/multicycle_fsm_alu_decoder.sv - funct3/funct7 to ALU op for register and immediate ALU instructions
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [3:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control_o = ALU_SLL;
            3'b010:  alu_control_o = ALU_SLT;
            3'b011:  alu_control_o = ALU_SLTU;
            3'b100:  alu_control_o = ALU_XOR;
            // Shift-right arithmetic is selected by bit 30 for both SRA and SRAI.
            3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control_o = ALU_OR;
            default: alu_control_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// rtl/multicycle_fsm.sv - multicycle RV32I control sequencer with memory wait states and illegal-opcode trap
module multicycle_fsm
    import multicycle_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_src,
    output logic        reg_write,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state_o
);

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  dec_alu;
    logic        unused_instr_bits;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign state_o = state_q;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3_i      (funct3),
        .funct7b5_i    (instr[30]),
        .is_rtype_i    (state_q == S_EXECR),
        .alu_control_o (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= RESET_STATE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        reg_write   = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed into ALUOut while the opcode is decoded.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_control = dec_alu;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = dec_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                retire      = 1'b1;
                alu_control = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                state_d     = S_FETCH;
                case (funct3)
                    3'b000, 3'b101, 3'b111: pc_write = zero;
                    3'b001, 3'b100, 3'b110: pc_write = !zero;
                    default:                state_d  = S_TRAP;
                endcase
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JAL;
            end
            S_LUI: begin
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_U;
                alu_control = ALU_PASSB;
                state_d     = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = RESET_STATE;
        endcase
        if (!resetn) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 4'b0000;
            imm_src     = 3'b000;
            reg_write   = 1'b0;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule
